wave_window_sched: RTL
======================

Name: wave_window_sched

Overview:
- Run-control and configuration scheduler for the two-window waveform counter datapath.
- Holds a programmable period and two programmable windows (f: active-low window; g: active-high window) behind a valid/ready config port.
- Sequences start/stop/one-shot operation.
- Applies new settings glitch-free, only at a period boundary.

Parameters:
- CNT_W, 10, counter and threshold width.
- DEF_PERIOD, 900, active period after reset; counter runs 0..period inclusive.
- DEF_F_LO, 50, f window lower bound (exclusive).
- DEF_F_HI, 250, f window upper bound (exclusive).
- DEF_G_LO, 150, g window lower bound (exclusive).
- DEF_G_HI, 400, g window upper bound (exclusive).

Ports:
- clock  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  pulse: begin running.
- stop  in  1  pulse: finish current period, then idle.
- oneshot  in  1  sampled with start; 1 = run exactly one period.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when valid&ready.
- cfg_sel  in  3  target: 0 period, 1 f_lo, 2 f_hi, 3 g_lo, 4 g_hi; 5-7 ignored.
- cfg_data  in  CNT_W  write data.
- cfg_commit  in  1  pulse: schedule shadow -> active copy.
- busy  out  1  state != IDLE.
- count  out  CNT_W  current counter value.
- f  out  1  waveform f.
- g  out  1  waveform g.
- wrap  out  1  one-cycle pulse when count wraps period -> 0.
- done  out  1  one-cycle pulse on entry to IDLE from RUN/DRAIN.

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clock. On reset:
  - state IDLE; count=0; f=0, g=0; wrap=0, done=0, busy=0.
  - Shadow and active registers = DEF_*; commit_pending=0; cfg_ready=1.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN: on start. Latches oneshot into os_r; count starts from 0.
  - RUN -> DRAIN: on stop.
  - RUN -> IDLE: os_r=1 and count==period, at that edge.
  - DRAIN -> IDLE: count==period.
  - DRAIN -> RUN: on start (cancels stop).
  - start and stop in the same cycle: stop wins (IDLE stays IDLE; RUN -> DRAIN).
- Counter, in RUN/DRAIN:
  - count <= (count==period) ? 0 : count+1.
  - wrap=1 in the cycle after count==period.
  - Entering IDLE forces count=0. count holds 0 in IDLE.
- Outputs are registered and computed from the pre-edge count value c (one-cycle latency):
  - f <= !(f_lo < c && c < f_hi).
  - g <= (g_lo < c && c < g_hi).
  - In IDLE, and on the IDLE-entry edge, f=0 and g=0.
  - Comparisons are unsigned, CNT_W-bit, strict.
  - An empty window (lo >= hi-1) gives f constantly 1 and g constantly 0 while running.
- Config port:
  - Write accepted when cfg_valid && cfg_ready; sets shadow[cfg_sel]. Writes with cfg_sel >= 5 are accepted and dropped.
  - cfg_ready = !commit_pending.
  - cfg_commit in IDLE: active <= shadow on the next edge.
  - cfg_commit in RUN/DRAIN: commit_pending=1; copy occurs on the edge where count==period, so the new period starts from count=0 with new values. commit_pending clears on the same edge.
  - cfg_commit while already pending: no effect.
  - Write and commit in the same cycle: the write lands in shadow first, and the commit includes it.
  - Period value 0 is legal: count stays 0 and wrap pulses every cycle.
- Reset mid-operation: everything returns to reset values, including shadow (pending commits are lost).
- done pulses one cycle on any RUN/DRAIN -> IDLE transition.

Optional Feature:
- Macro: WAVE_WINDOW_SCHED_PCNT_EN.
- Defined: adds output port pcnt [15:0].
  - pcnt is cleared on IDLE -> RUN.
  - Increments on each wrap, saturating at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, start with oneshot=0, defaults:
  - f=1 except low for count values 51..249 (observed one cycle later).
  - g=1 for count values 151..399.
  - wrap pulse every 901 cycles.
- Write period=9, f_lo=2, f_hi=5 in IDLE, commit, start:
  - f low for c=3,4; wrap every 10 cycles.
- While RUN with period=9 at count=4, write period=4 and commit:
  - cfg_ready drops.
  - Counter reaches 9, then runs 0..4.
  - cfg_ready returns at the wrap.
- Stop at count=3, period=9:
  - busy stays 1 through count 9.
  - done pulse; then f=g=0, count=0.
- start+stop same cycle in RUN:
  - Goes DRAIN.
  - start again at count=5 -> back to RUN; no done pulse.
- oneshot=1, period=4:
  - Exactly 5 counted cycles, one done pulse, then IDLE.
- Assert resetn=0 mid-RUN:
  - Next edge: count=0, f=g=0, busy=0, pcnt=0 (if enabled).

Source files
------------

// File: rtl/wave_window_sched.sv
// wave_window_sched: run-control and configuration scheduler for the
// two-window waveform counter datapath.
//
// A free-running counter sweeps 0..period. Two registered waveforms come from
// comparing the counter with programmable windows:
//   f : low while f_lo < count < f_hi, otherwise high
//   g : high while g_lo < count < g_hi, otherwise low
// Settings are written into a shadow bank through a valid/ready port. A commit
// copies shadow -> active immediately when idle. While running, the copy waits
// for the period boundary so that a period never mixes old and new settings.
//
// Ports:
//   clock, resetn        clock, synchronous active-low reset
//   start, stop, oneshot run control (oneshot is sampled together with start)
//   cfg_valid/cfg_ready  config write handshake; cfg_sel picks the target
//                        (0 period, 1 f_lo, 2 f_hi, 3 g_lo, 4 g_hi, 5-7 dropped)
//   cfg_data, cfg_commit write data; commit pulse for shadow -> active
//   busy                 high whenever not idle
//   count                current counter value
//   f, g                 waveforms, one cycle behind count
//   wrap                 one-cycle pulse after count == period
//   done                 one-cycle pulse on return to idle
//
// Optional build macro WAVE_WINDOW_SCHED_PCNT_EN adds pcnt[15:0], a saturating
// count of wraps since the last start from idle.
module wave_window_sched #(
  parameter int CNT_W      = 10,
  parameter int DEF_PERIOD = 900,
  parameter int DEF_F_LO   = 50,
  parameter int DEF_F_HI   = 250,
  parameter int DEF_G_LO   = 150,
  parameter int DEF_G_HI   = 400
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             f,
  output logic             g,
  output logic             wrap,
  output logic             done
`ifdef WAVE_WINDOW_SCHED_PCNT_EN
  ,
  output logic [15:0]      pcnt
`endif
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] f_lo;
    logic [CNT_W-1:0] f_hi;
    logic [CNT_W-1:0] g_lo;
    logic [CNT_W-1:0] g_hi;
  } cfg_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam cfg_t CFG_DEF = '{
    period: CNT_W'(DEF_PERIOD),
    f_lo:   CNT_W'(DEF_F_LO),
    f_hi:   CNT_W'(DEF_F_HI),
    g_lo:   CNT_W'(DEF_G_LO),
    g_hi:   CNT_W'(DEF_G_HI)
  };

  state_t state, nxt;
  cfg_t   shd, shd_nxt, act;
  logic   pend, os_r;
  logic   running, at_end, f_in, g_in;

  assign running   = (state != IDLE);
  assign at_end    = (count == act.period);
  assign busy      = running;
  assign cfg_ready = !pend;
  assign f_in      = (act.f_lo < count) && (count < act.f_hi);
  assign g_in      = (act.g_lo < count) && (count < act.g_hi);

  // Shadow view including this cycle's accepted write, so a commit issued in
  // the same cycle as a write picks the write up.
  always_comb begin
    shd_nxt = shd;
    if (cfg_valid && cfg_ready) begin
      case (cfg_sel)
        3'd0:    shd_nxt.period = cfg_data;
        3'd1:    shd_nxt.f_lo   = cfg_data;
        3'd2:    shd_nxt.f_hi   = cfg_data;
        3'd3:    shd_nxt.g_lo   = cfg_data;
        3'd4:    shd_nxt.g_hi   = cfg_data;
        default: ;
      endcase
    end
  end

  // Stop beats start in the same cycle. Reaching the end of a final period
  // (oneshot or draining) beats any start/stop seen on that same edge.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start && !stop) nxt = RUN;
      RUN:     if (os_r && at_end) nxt = IDLE;
               else if (stop)      nxt = DRAIN;
      DRAIN:   if (at_end)                nxt = IDLE;
               else if (start && !stop)   nxt = RUN;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      os_r  <= 1'b0;
      count <= '0;
      f     <= 1'b0;
      g     <= 1'b0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      shd   <= CFG_DEF;
      act   <= CFG_DEF;
      pend  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == RUN) os_r <= oneshot;

      // Idle (and the edge into idle) pins count to 0; a fresh start therefore
      // begins counting from 0 on the first running edge.
      count <= (!running || nxt == IDLE || at_end) ? '0 : count + 1'b1;
      wrap  <= running && at_end;
      done  <= running && (nxt == IDLE);
      f     <= running && (nxt != IDLE) && !f_in;
      g     <= running && (nxt != IDLE) && g_in;

      shd <= shd_nxt;
      if (!running) begin
        if (cfg_commit) act <= shd_nxt;
      end else if (at_end) begin
        // Period boundary: apply a pending (or just-issued) commit so the
        // next period starts cleanly on the new settings.
        if (pend || cfg_commit) act <= shd_nxt;
        pend <= 1'b0;
      end else if (cfg_commit) begin
        pend <= 1'b1;
      end
    end
  end

`ifdef WAVE_WINDOW_SCHED_PCNT_EN
  always_ff @(posedge clock) begin
    if (!resetn)                                     pcnt <= '0;
    else if (state == IDLE && nxt == RUN)            pcnt <= '0;
    else if (running && at_end && pcnt != 16'hFFFF)  pcnt <= pcnt + 16'd1;
  end
`endif

endmodule
